// File: rtl/obs_pkg.sv
// Shared definitions for the observed-count producer and its chi_squared consumer,
// so both ends agree on the bin count and the count width.
package obs_pkg;
    typedef enum logic [1:0] {COLLECT, DONE, SERVE, WAIT} obs_state_t;

    localparam int DOF   = 5;
    localparam int NBINS = DOF + 1;

    function automatic int cnt_width(input int popsize);
        return $clog2(popsize) + 8;
    endfunction
endpackage

// File: rtl/obs_bin_server_sat_counter.sv
// Unsigned counter that sticks at all-ones instead of wrapping; one per histogram bin.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/obs_bin_server.sv
// Histograms classified samples into DoF+1 bins, then serves one bin count per read
// request to chi_squared; re-arms once chi_squared reports its result.
module obs_bin_server
    import obs_pkg::*;
#(
    parameter int DoF      = DOF,
    parameter int POPSIZE  = 100,
    parameter int NSAMPLES = 25600,
    parameter int CW       = cnt_width(POPSIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          smp_vld,
    input  logic [2:0]    smp_bin,
    output logic          smp_rdy,
    input  logic          rd_rqst,
    input  logic          chi_vld,
    output logic          calc_done,
    output logic          data_rdy,
    output logic [CW-1:0] O_out,
    output logic          bin_err
);
    localparam int NB = DoF + 1;
    localparam int SW = $clog2(NSAMPLES + 1);
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;

    obs_state_t    state, state_nxt;
    logic [SW-1:0] smp_cnt;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt [NB];
    logic          legal, take, last_smp, rearm, rd_take, last_rd;

    assign legal    = int'(smp_bin) <= DoF;
    assign take     = (state == COLLECT) && smp_vld && legal;
    assign last_smp = take && (smp_cnt == SW'(NSAMPLES - 1));
    assign rearm    = (state == WAIT) && chi_vld;
    assign rd_take  = (state == SERVE) && rd_rqst;
    assign last_rd  = rd_take && (ptr == PW'(DoF));

    assign smp_rdy   = (state == COLLECT);
    assign calc_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_smp) state_nxt = DONE;
            DONE:    state_nxt = SERVE;
            SERVE:   if (last_rd) state_nxt = WAIT;
            WAIT:    if (rearm) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    for (genvar i = 0; i < NB; i++) begin : g_bin
        sat_counter #(.W(CW)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (rearm),
            .inc (take && (int'(smp_bin) == i)),
            .q   (cnt[i])
        );
    end

    // Illegal bins are flagged but never counted toward the run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt  <= '0;
            ptr      <= '0;
            O_out    <= '0;
            data_rdy <= 1'b0;
            bin_err  <= 1'b0;
        end else begin
            data_rdy <= rd_take;
            if (rd_take) begin
                O_out <= cnt[ptr];
                ptr   <= ptr + 1'b1;
            end
            if (state == DONE) ptr <= '0;
            if (take) smp_cnt <= smp_cnt + 1'b1;
            if (rearm) begin
                smp_cnt <= '0;
                bin_err <= 1'b0;
            end else if ((state == COLLECT) && smp_vld && !legal) begin
                bin_err <= 1'b1;
            end
        end
    end
endmodule
